reg_sig_arbiter: RTL and testbench
==================================

# reg_sig_arbiter

Round-robin arbiter and encoder for register bus drive requests: the reverse of the binary-to-register-select decode. It takes up to eight concurrent one-hot register drive requests from the datapath and grants exactly one at a time. It outputs the winner as a 4-bit binary index with a valid flag, matching the `{enable, bin}` format the register-select decoder consumes, plus a one-hot grant. Each grant is held until the bus transfer completes.

## Interface
- `N_REQ`, default 8: number of request lines; fixed at 8, index encoding fits `bin[2:0]`.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `r_req`, input, 8: request vector; bit i high means register i requests the bus.
- `done`, input, 1: the current transfer completes this cycle; meaningful only while `valid`=1.
- `bin`, output, 4: registered binary index of the granted register; `bin[3]` is always 0.
- `valid`, output, 1: registered; high while a grant is active. Pairs with `bin` as the decoder's enable.
- `grant`, output, 8: registered one-hot grant; equals `1 << bin[2:0]` when `valid`=1, else 0.
- `ptr`, output, 3: round-robin pointer (debug/verification visibility).

## Operation
- States:
  - IDLE: no grant.
  - BUSY: grant held.
- Arbitration function `pick(req, ptr)`:
  - Scan indices `ptr, ptr+1, …, 7, 0, …, ptr-1` (mod 8).
  - The first index with its `req` bit set wins.
- IDLE:
  - If `r_req != 0`: at the next edge load `bin = {1'b0, w}`, `grant[w]=1`, `valid=1`, `ptr = w+1 mod 8`, where `w = pick(r_req, ptr)`. Enter BUSY.
  - Else stay in IDLE with outputs 0.
- BUSY, current index c:
  - Release condition R: `done`=1, or `r_req[c]`=0 (withdrawal aborts the grant).
  - Not R: hold all outputs and `ptr` unchanged. Other request lines are ignored.
  - R with `m = r_req & ~(1<<c)` nonzero: re-arbitrate at the same edge with no bubble. New winner is `pick(m, ptr)`; `ptr` updates as in IDLE; stay in BUSY.
  - R with m = 0: go to IDLE and clear `bin`, `grant`, `valid`. `ptr` keeps its value.
  - Releasing index c is excluded from re-arbitration in that cycle, even if `r_req[c]` stays high. It may win again one cycle later.
- `done` while IDLE is ignored.
- Invariants:
  - `grant` is always zero or one-hot.
  - `valid == |grant`.
  - `bin[3]==0`.
  - `bin[2:0]` encodes `grant` whenever valid.

## Timing
- Reset, synchronous: at the first edge with `reset`=1 the block sets `bin=4'b0000`, `grant=8'h00`, `valid=0`, `ptr=3'd0`, state IDLE. This overrides any request or `done`.
- Reset asserted mid-grant drops the grant at that edge. No completion is implied.
- Request-to-grant latency: 1 cycle. `r_req` sampled at edge k produces `grant` and `valid` visible after edge k.
- Release-to-next-grant: 0 idle cycles when another request is pending. `done` sampled at edge k switches `grant` directly to the new winner at edge k.
- Minimum grant length: 1 cycle. `done` may be high in the first cycle after the grant.
- Pointer wrap-around: winner 7 sets `ptr` to 0.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Reset and idle:
  - Assert `reset` 2 cycles with `r_req=8'hFF` and `done=1`. Outputs must stay `bin=0`, `grant=0`, `valid=0`, `ptr=0`.
  - Release reset with `r_req=0` for 3 cycles. Outputs must stay 0.
- Single request:
  - `r_req=8'h20`. One edge later: `bin=4'b0101`, `grant=8'h20`, `valid=1`, `ptr=6`.
  - Hold 3 cycles, then `done=1` with request still high. Next edge: IDLE, all outputs 0.
- Round-robin fairness:
  - From reset, hold `r_req=8'h81` and pulse `done` every cycle.
  - Grant sequence must be 0, 7, 0, 7 (`bin` 0, 7, 0, 7) with `valid` continuously 1.
  - `ptr` sequence must be 1, 0, 1, 0, exercising wrap from 7 to 0.
- Back-to-back with no bubble:
  - `r_req=8'h0E`, `done` high on every granted cycle.
  - Grants must be 1, 2, 3 on consecutive cycles, then IDLE once requests drop.
- Withdrawal abort:
  - Granted index 4, with `r_req` changing from `8'h10` to `8'h01` and `done=0`.
  - Next edge: `bin=0`, `grant=8'h01`, `valid=1`.
- Reset mid-grant:
  - While granted index 3, assert `reset` with `r_req=8'h08` held.
  - Next edge: all outputs 0, `ptr=0`.
  - After `reset` deasserts, index 3 is re-granted one cycle later.

Source files
------------

// File: rtl/reg_sig_arbiter_if.sv
// Request/grant bundle between the datapath and the register-bus arbiter.
// The datapath side drives requests and transfer completion; the arbiter returns the grant.
interface reg_sig_arbiter_if;
  logic [7:0] r_req;
  logic       done;
  logic [3:0] bin;
  logic       valid;
  logic [7:0] grant;
  logic [2:0] ptr;

  modport master (output r_req, done, input bin, valid, grant, ptr);
  modport slave  (input r_req, done, output bin, valid, grant, ptr);
endinterface

// File: rtl/reg_sig_arbiter.sv
// Round-robin arbiter for register drive requests; encodes the held winner as
// {valid, bin} for the register-select decoder, plus a one-hot grant.
module reg_sig_arbiter #(
  parameter int N_REQ = 8
) (
  input  logic        clk,
  input  logic        reset,
  reg_sig_arbiter_if.slave bus
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t     r_state;
  logic [3:0] r_bin;
  logic       r_valid;
  logic [7:0] r_grant;
  logic [2:0] r_ptr;

  logic [7:0] w_cand;
  logic       w_release;
  logic       w_hit;
  logic [2:0] w_win;
  logic       w_load;
  logic       w_clear;

  // Walking the scan backwards lets the lowest offset from p overwrite the result last.
  function automatic logic [3:0] pick(input logic [7:0] req, input logic [2:0] p);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'b0000;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = p + 3'(k);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    w_release = bus.done | ~bus.r_req[r_bin[2:0]];
    // The releasing index sits out the re-arbitration in its release cycle.
    w_cand = (r_state == S_BUSY) ? (bus.r_req & ~r_grant) : bus.r_req;
    {w_hit, w_win} = pick(w_cand, r_ptr);
    w_load  = w_hit && ((r_state == S_IDLE) || w_release);
    w_clear = (r_state == S_BUSY) && w_release && !w_hit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_bin   <= 4'b0000;
      r_valid <= 1'b0;
      r_grant <= 8'h00;
      r_ptr   <= 3'd0;
    end else if (w_load) begin
      r_state <= S_BUSY;
      r_bin   <= {1'b0, w_win};
      r_valid <= 1'b1;
      r_grant <= 8'd1 << w_win;
      r_ptr   <= w_win + 3'd1;
    end else if (w_clear) begin
      r_state <= S_IDLE;
      r_bin   <= 4'b0000;
      r_valid <= 1'b0;
      r_grant <= 8'h00;
    end
  end

  assign bus.bin   = r_bin;
  assign bus.valid = r_valid;
  assign bus.grant = r_grant;
  assign bus.ptr   = r_ptr;

endmodule

// File: tb/tb_reg_sig_arbiter.sv
// Scoreboard bench for reg_sig_arbiter: stimulus pushes model predictions,
// a negedge monitor pops and compares them against the arbiter outputs.
module tb_reg_sig_arbiter;

  logic clk;
  logic reset;

  reg_sig_arbiter_if bus ();

  reg_sig_arbiter #(.N_REQ(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] bin;
    logic       valid;
    logic [7:0] grant;
    logic [2:0] ptr;
  } exp_t;

  exp_t q[$];
  int   edge_cnt = 0;
  int   tests    = 0;
  int   fails    = 0;

  // Reference model: granted index (-1 when none) and the rotating pointer.
  int m_g = -1;
  int m_p = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic int model_pick(input logic [7:0] req, input int p);
    for (int k = 0; k < 8; k++) begin
      int idx;
      idx = (p + k) % 8;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [7:0] req, input logic dn, input logic rst);
    logic [7:0] m;
    int w;
    if (rst) begin
      m_g = -1;
      m_p = 0;
    end else if (m_g < 0) begin
      w = model_pick(req, m_p);
      if (w >= 0) begin
        m_g = w;
        m_p = (w + 1) % 8;
      end
    end else if (dn || !req[m_g]) begin
      m = req;
      m[m_g] = 1'b0;
      w = model_pick(m, m_p);
      if (w >= 0) begin
        m_g = w;
        m_p = (w + 1) % 8;
      end else begin
        m_g = -1;
      end
    end
  endtask

  task automatic step(input logic [7:0] req, input logic dn, input logic rst);
    exp_t e;
    @(posedge clk);
    #1;
    bus.r_req = req;
    bus.done  = dn;
    reset     = rst;
    model_step(req, dn, rst);
    e.cyc   = edge_cnt + 1;
    e.valid = (m_g >= 0);
    e.bin   = (m_g >= 0) ? 4'(m_g) : 4'd0;
    e.grant = (m_g >= 0) ? (8'd1 << m_g) : 8'h00;
    e.ptr   = 3'(m_p);
    q.push_back(e);
    $display("[TB] edge %0d: drive req=%h done=%b reset=%b -> expect valid=%b bin=%0d grant=%h ptr=%0d",
             e.cyc, req, dn, rst, e.valid, e.bin, e.grant, e.ptr);
  endtask

  task automatic chk(input string name, input int cyc, input int act, input int exp_v);
    tests++;
    if (act != exp_v) begin
      fails++;
      $display("[TB] FAIL %s at edge %0d: got %0h, expected %0h", name, cyc, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0 && q[0].cyc == edge_cnt) begin
      exp_t e;
      e = q.pop_front();
      chk("valid", e.cyc, int'(bus.valid), int'(e.valid));
      chk("bin",   e.cyc, int'(bus.bin),   int'(e.bin));
      chk("grant", e.cyc, int'(bus.grant), int'(e.grant));
      chk("ptr",   e.cyc, int'(bus.ptr),   int'(e.ptr));
    end
  end

  initial begin
    reset     = 1'b1;
    bus.r_req = 8'h00;
    bus.done  = 1'b0;

    // Reset overrides requests and done, then idle with no requests.
    repeat (2) step(8'hFF, 1'b1, 1'b1);
    repeat (3) step(8'h00, 1'b0, 1'b0);

    // Single request, held, then completed.
    repeat (4) step(8'h20, 1'b0, 1'b0);
    step(8'h20, 1'b1, 1'b0);
    step(8'h00, 1'b0, 1'b0);

    // Fairness between 0 and 7 with pointer wrap.
    step(8'h00, 1'b0, 1'b1);
    repeat (5) step(8'h81, 1'b1, 1'b0);

    // Back-to-back grants 1, 2, 3 then idle.
    step(8'h00, 1'b0, 1'b1);
    step(8'h0E, 1'b0, 1'b0);
    step(8'h0E, 1'b1, 1'b0);
    step(8'h0E, 1'b1, 1'b0);
    step(8'h00, 1'b1, 1'b0);

    // Withdrawal abort from 4 to 0.
    step(8'h00, 1'b0, 1'b1);
    step(8'h10, 1'b0, 1'b0);
    step(8'h01, 1'b0, 1'b0);

    // Reset in the middle of a grant, then re-grant.
    step(8'h00, 1'b0, 1'b1);
    step(8'h08, 1'b0, 1'b0);
    step(8'h08, 1'b0, 1'b1);
    step(8'h08, 1'b0, 1'b0);
    step(8'h08, 1'b0, 1'b0);

    // Randomized traffic with sparse requests, frequent done and rare resets.
    for (int i = 0; i < 400; i++) begin
      logic [7:0] rq;
      logic       dn;
      logic       rs;
      rq = 8'($urandom) & 8'($urandom);
      if ($urandom_range(0, 9) == 0) rq = 8'h00;
      dn = ($urandom_range(0, 2) == 0);
      rs = ($urandom_range(0, 59) == 0);
      step(rq, dn, rs);
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (q.size() > 0) begin
      fails++;
      $display("[TB] FAIL drain: %0d predictions left unchecked, expected 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
